square_dac_tx: RTL and testbench

- Downstream stage of the square-wave DDS.
- Takes the signed 14-bit `data` samples the DDS produces, applies a signed DC offset with saturation, and converts each result to 14-bit offset-binary.
- Serialises each converted sample as a 16-bit SPI frame to an external DAC.
- A one-deep holding register absorbs a sample that arrives while a frame is in flight.

---
 rtl/dds_pkg.sv | 18 +
 rtl/dac_sample_fmt.sv | 32 +++
 rtl/square_dac_tx.sv | 171 +++++++++++++++++
 tb/tb_square_dac_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Constants and FSM state type shared by the square-wave DDS output stages.
package dds_pkg;

    localparam int DATA_W  = 14;
    localparam int FRAME_W = 16;

    localparam logic [DATA_W-1:0] OFFSET_BIN_MSB = 14'h2000;

    localparam int SAT_MAX = 8191;
    localparam int SAT_MIN = -8192;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/dac_sample_fmt.sv
// Combinational sample formatter: signed add of a DC offset, saturation to
// 14 bits, conversion to offset-binary and prefixing of the two control bits.
module dac_sample_fmt
    import dds_pkg::*;
#(
    parameter logic [1:0] FRAME_CTRL = 2'b00
) (
    input  logic signed [DATA_W-1:0] data_in,
    input  logic signed [DATA_W-1:0] offset,
    output logic        [FRAME_W-1:0] frame
);

    localparam logic signed [DATA_W:0] SUM_MAX = 15'(SAT_MAX);
    localparam logic signed [DATA_W:0] SUM_MIN = 15'(SAT_MIN);

    logic signed [DATA_W:0]   sum;
    logic        [DATA_W-1:0] sat;

    always_comb begin
        // One extra bit of headroom makes the add itself overflow-free.
        sum = {data_in[DATA_W-1], data_in} + {offset[DATA_W-1], offset};
        if (sum > SUM_MAX) begin
            sat = SUM_MAX[DATA_W-1:0];
        end else if (sum < SUM_MIN) begin
            sat = SUM_MIN[DATA_W-1:0];
        end else begin
            sat = sum[DATA_W-1:0];
        end
        frame = {FRAME_CTRL, sat ^ OFFSET_BIN_MSB};
    end

endmodule

// File: rtl/square_dac_tx.sv
// SPI transmitter feeding converted DDS samples to an external DAC, with a
// one-deep holding register for samples that arrive while a frame is in flight.
module square_dac_tx
    import dds_pkg::*;
#(
    parameter int         CLK_DIV    = 2,
    parameter logic [1:0] FRAME_CTRL = 2'b00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     data_valid,
    input  logic signed [DATA_W-1:0] offset,
    output logic                     dac_cs_n,
    output logic                     dac_sclk,
    output logic                     dac_sdo,
    output logic                     busy,
    output logic                     overrun
);

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    tx_state_e          state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic [3:0]         bit_q, bit_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               sdo_q, sdo_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    logic [FRAME_W-1:0] fmt_frame;
    logic [FRAME_W-1:0] load_frame;
    logic               accept, load, capture, end_gap;

    dac_sample_fmt #(
        .FRAME_CTRL (FRAME_CTRL)
    ) u_fmt (
        .data_in (data_in),
        .offset  (offset),
        .frame   (fmt_frame)
    );

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        sdo_d       = sdo_q;
        overrun_d   = 1'b0;
        load        = 1'b0;
        load_frame  = fmt_frame;
        capture     = 1'b0;
        accept      = en && data_valid;
        end_gap     = (state_q == ST_GAP) && (div_q == DIV_MAX);

        unique case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                capture = accept;
                if (div_q == DIV_MAX) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = ST_GAP;
                            cs_n_d  = 1'b1;
                            sdo_d   = 1'b0;
                            bit_d   = '0;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                            sdo_d   = shift_q[FRAME_W-2];
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (end_gap) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    div_d   = div_q + 8'd1;
                    capture = accept;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The held sample always goes out before one arriving in the same cycle.
        if (state_q == ST_IDLE || end_gap) begin
            if (en && pend_full_q) begin
                load        = 1'b1;
                load_frame  = pend_q;
                pend_full_d = 1'b0;
                capture     = accept;
            end else if (accept) begin
                load = 1'b1;
            end
        end

        if (capture) begin
            pend_d      = fmt_frame;
            overrun_d   = pend_full_d;
            pend_full_d = 1'b1;
        end

        if (!en) begin
            pend_full_d = 1'b0;
        end

        if (load) begin
            state_d = ST_SHIFT;
            shift_d = load_frame;
            sdo_d   = load_frame[FRAME_W-1];
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            div_d   = '0;
            bit_d   = '0;
        end

        busy_d = (state_d != ST_IDLE) || pend_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            sdo_q       <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            sdo_q       <= sdo_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_sdo  = sdo_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_square_dac_tx.sv
// Directed bench for square_dac_tx: a table of sample/offset/frame vectors
// plus hand-written back-to-back, overrun, reset and enable sequences.
module tb_square_dac_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [13:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic [13:0] offset = '0;
    logic        dac_cs_n, dac_sclk, dac_sdo, busy, overrun;

    square_dac_tx #(
        .CLK_DIV    (2),
        .FRAME_CTRL (2'b00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data_in    (data_in),
        .data_valid (data_valid),
        .offset     (offset),
        .dac_cs_n   (dac_cs_n),
        .dac_sclk   (dac_sclk),
        .dac_sdo    (dac_sdo),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [15:0] rx_q[$];
    int          len_q[$];
    int          rise_q[$];
    int          gap_q[$];
    int          busy_runs[$];

    int          low_cnt, rises, high_cnt, busy_run, starts, ov_cnt;
    logic [15:0] word;
    bit          in_frame, prev_sclk, have_rise;

    // Bus monitor: reconstructs frames from sclk rising edges on the falling clk edge.
    always @(negedge clk) begin
        if (rst) begin
            in_frame  = 1'b0;
            busy_run  = 0;
            have_rise = 1'b0;
        end else begin
            if (dac_cs_n === 1'b0) begin
                if (!in_frame) begin
                    in_frame  = 1'b1;
                    low_cnt   = 0;
                    rises     = 0;
                    word      = '0;
                    prev_sclk = 1'b0;
                    starts++;
                    if (have_rise) gap_q.push_back(high_cnt);
                end
                low_cnt++;
                if (dac_sclk && !prev_sclk) begin
                    word = {word[14:0], dac_sdo};
                    rises++;
                end
                prev_sclk = dac_sclk;
            end else begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    rx_q.push_back(word);
                    len_q.push_back(low_cnt);
                    rise_q.push_back(rises);
                    have_rise = 1'b1;
                    high_cnt  = 0;
                end
                high_cnt++;
            end
            if (busy === 1'b1) begin
                busy_run++;
            end else if (busy_run != 0) begin
                busy_runs.push_back(busy_run);
                busy_run = 0;
            end
            if (overrun === 1'b1) ov_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_valid(input logic [13:0] d, input logic [13:0] o);
        @(posedge clk);
        #1;
        data_in    = d;
        offset     = o;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rx_q.size() < n && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (rx_q.size() < n) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", rx_q.size(), n);
        end
    endtask

    task automatic expect_frames(input int n);
        wait_rx(n);
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            check("frame_word", 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
            check("cs_low_cycles", 32'(len_q.pop_front()), 32'd64);
            check("sclk_rises", 32'(rise_q.pop_front()), 32'd16);
        end
        exp_q.delete();
        rx_q.delete();
        len_q.delete();
        rise_q.delete();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_busy_run(input string name, input int exp_len);
        if (busy_runs.size() == 0) begin
            check(name, 32'd0, 32'(exp_len));
        end else begin
            check(name, 32'(busy_runs.pop_front()), 32'(exp_len));
        end
        busy_runs.delete();
    endtask

    typedef struct {
        logic [13:0] data;
        logic [13:0] off;
        logic [15:0] frame;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int s0, ov0;

        vecs[0] = '{14'd0,     14'd0,     16'h2000};
        vecs[1] = '{14'd8191,  14'd100,   16'h3FFF};
        vecs[2] = '{14'h2000,  14'h3FFF,  16'h0000};
        vecs[3] = '{14'h3FFF,  14'd0,     16'h1FFF};
        vecs[4] = '{14'd100,   14'h3F38,  16'h1F9C};
        vecs[5] = '{14'h20C0,  14'h3E0C,  16'h0000};
        vecs[6] = '{14'd4000,  14'd4191,  16'h3FFF};
        vecs[7] = '{14'd4000,  14'd4192,  16'h3FFF};
        vecs[8] = '{14'h2000,  14'd1,     16'h0001};
        vecs[9] = '{14'd8191,  14'h3FFF,  16'h3FFE};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cs_n", 32'(dac_cs_n), 32'd1);
        check("rst_sclk", 32'(dac_sclk), 32'd0);
        check("rst_sdo", 32'(dac_sdo), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(vecs[i].frame);
            pulse_valid(vecs[i].data, vecs[i].off);
            expect_frames(1);
            check_busy_run("busy_single", 66);
        end

        // Back-to-back: each new valid lands on the last GAP cycle.
        gap_q.delete();
        ov0 = ov_cnt;
        exp_q.push_back(16'h2001);
        exp_q.push_back(16'h2002);
        exp_q.push_back(16'h2003);
        pulse_valid(14'd1, 14'd0);
        repeat (64) @(posedge clk);
        pulse_valid(14'd2, 14'd0);
        repeat (64) @(posedge clk);
        pulse_valid(14'd3, 14'd0);
        expect_frames(3);
        check("b2b_gap_count", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() == 3) begin
            check("b2b_gap1", 32'(gap_q[1]), 32'd2);
            check("b2b_gap2", 32'(gap_q[2]), 32'd2);
        end
        check("b2b_overruns", 32'(ov_cnt - ov0), 32'd0);
        check_busy_run("busy_b2b", 198);

        // Three valids inside one frame: latest pending wins.
        ov0 = ov_cnt;
        exp_q.push_back(16'h2005);
        exp_q.push_back(16'h2007);
        pulse_valid(14'd5, 14'd0);
        pulse_valid(14'd6, 14'd0);
        check("overrun_after_second", 32'(overrun), 32'd0);
        pulse_valid(14'd7, 14'd0);
        check("overrun_after_third", 32'(overrun), 32'd1);
        expect_frames(2);
        check("overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
        check_busy_run("busy_overrun", 132);

        // Reset 20 cycles into a frame.
        s0 = starts;
        pulse_valid(14'd3, 14'd0);
        repeat (18) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_cs_n", 32'(dac_cs_n), 32'd1);
        check("midrst_sclk", 32'(dac_sclk), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sdo", 32'(dac_sdo), 32'd0);
        repeat (150) @(posedge clk);
        #1;
        check("midrst_starts", 32'(starts - s0), 32'd1);
        check("midrst_no_frame", 32'(rx_q.size()), 32'd0);
        rx_q.delete();
        len_q.delete();
        rise_q.delete();
        busy_runs.delete();

        // en dropped mid-frame with a sample pending.
        s0 = starts;
        exp_q.push_back(16'h2009);
        pulse_valid(14'd9, 14'd0);
        pulse_valid(14'd10, 14'd0);
        repeat (10) @(posedge clk);
        #1;
        en = 1'b0;
        @(negedge clk);
        check("en_low_busy", 32'(busy), 32'd1);
        expect_frames(1);
        check("en_low_busy_after", 32'(busy), 32'd0);
        check_busy_run("busy_en_low", 66);
        pulse_valid(14'd11, 14'd0);
        repeat (100) @(posedge clk);
        #1;
        en = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("en_low_starts", 32'(starts - s0), 32'd1);
        check("en_low_no_pending", 32'(rx_q.size()), 32'd0);

        exp_q.push_back(16'h2004);
        pulse_valid(14'd7, 14'h3FFD);
        expect_frames(1);
        check_busy_run("busy_recover", 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
